// File: rtl/uart_pkg.sv
// +------------------------------------------------------------------+
// | uart_pkg: shared UART receive-path types, defaults and helpers.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_rx_state_e;

  localparam int OVERSAMPLE_RATE_DEFAULT = 16;
  localparam int DATA_SAMPLES_DEFAULT    = 3;

  // Parity bit a correct frame carries; narrower data is zero-extended by the caller.
  function automatic logic calc_parity(input logic [31:0] data, input logic even);
    return (^data) ^ ~even;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// +------------------------------------------------------------------+
// | uart_rx_sampler: 2-flop line synchronizer + majority-vote counter.|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int DATA_SAMPLES = DATA_SAMPLES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_rx,
  input  logic i_clear,
  input  logic i_sample,
  output logic o_rx_s,
  output logic o_result
);

  localparam int c_CNT_W = $clog2(DATA_SAMPLES + 1);

  logic [1:0]         r_sync;
  logic [c_CNT_W-1:0] r_ones;
  logic [c_CNT_W-1:0] w_ones;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_rx};
    end
  end

  assign o_rx_s = r_sync[1];

  // Result includes the sample taken this cycle so the caller can act on the window's last tick.
  assign w_ones   = r_ones + c_CNT_W'(i_sample & o_rx_s);
  assign o_result = (w_ones > c_CNT_W'(DATA_SAMPLES / 2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ones <= '0;
    end else if (i_clear) begin
      r_ones <= '0;
    end else begin
      r_ones <= w_ones;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// +------------------------------------------------------------------+
// | uart_receiver: oversampled LSB-first UART RX with valid/ready out.|
// | Optional macro UART_RX_BREAK_DETECT_EN enables break detection.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int OVERSAMPLE_RATE = OVERSAMPLE_RATE_DEFAULT,
  parameter int START_SAMPLES   = OVERSAMPLE_RATE / 4,
  parameter int DATA_SAMPLES    = DATA_SAMPLES_DEFAULT,
  parameter bit PARITY_EN       = 1'b0,
  parameter bit PARITY_EVEN     = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              oversample_tick,
  input  logic              RsRx,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_error,
  output logic              parity_error,
  output logic              overrun,
  output logic              busy,
  output logic              break_detect
);

  localparam int c_OS_W  = $clog2(OVERSAMPLE_RATE);
  localparam int c_BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [c_OS_W-1:0]  c_OS_LAST  = c_OS_W'(OVERSAMPLE_RATE - 1);
  localparam logic [c_OS_W-1:0]  c_START    = c_OS_W'(START_SAMPLES);
  localparam logic [c_OS_W-1:0]  c_WIN_LO   = c_OS_W'(OVERSAMPLE_RATE / 2 - DATA_SAMPLES / 2);
  localparam logic [c_OS_W-1:0]  c_WIN_HI   = c_OS_W'(OVERSAMPLE_RATE / 2 + DATA_SAMPLES / 2);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_W - 1);

  uart_rx_state_e      r_state;
  uart_rx_state_e      w_state_next;
  logic [c_OS_W-1:0]   r_os_cnt;
  logic [c_OS_W-1:0]   w_os_next;
  logic [c_BIT_W-1:0]  r_bit_cnt;
  logic [c_BIT_W-1:0]  w_bit_next;
  logic [DATA_W-1:0]   r_shift;
  logic                r_parity;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic                r_fe;
  logic                r_pe;
  logic                r_overrun;

  logic w_rx_s;
  logic w_maj;
  logic w_bit_state;
  logic w_in_win;
  logic w_win_end;
  logic w_clear;
  logic w_frame_done;
  logic w_is_break;
  logic w_par_err;

  assign w_bit_state = (r_state == DATA) || (r_state == PARITY) || (r_state == STOP);
  assign w_in_win    = oversample_tick && w_bit_state &&
                       (r_os_cnt >= c_WIN_LO) && (r_os_cnt <= c_WIN_HI);
  assign w_win_end   = oversample_tick && w_bit_state && (r_os_cnt == c_WIN_HI);
  assign w_clear     = (r_state == IDLE) || w_win_end;

  uart_rx_sampler #(
    .DATA_SAMPLES (DATA_SAMPLES)
  ) u_sampler (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_rx     (RsRx),
    .i_clear  (w_clear),
    .i_sample (w_in_win),
    .o_rx_s   (w_rx_s),
    .o_result (w_maj)
  );

`ifdef UART_RX_BREAK_DETECT_EN
  assign w_is_break = (r_shift == '0) && !w_maj;
`else
  assign w_is_break = 1'b0;
`endif

  assign w_par_err = PARITY_EN && (r_parity != calc_parity(32'(r_shift), PARITY_EVEN));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_os_cnt  <= w_os_next;
      r_bit_cnt <= w_bit_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_os_next    = r_os_cnt;
    w_bit_next   = r_bit_cnt;
    w_frame_done = 1'b0;
    if (oversample_tick) begin
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            w_state_next = START;
            w_os_next    = c_OS_W'(1);
          end
        end
        START: begin
          if ((r_os_cnt < c_START) && w_rx_s) begin
            w_state_next = IDLE;
            w_os_next    = '0;
          end else if (r_os_cnt == c_OS_LAST) begin
            w_state_next = DATA;
            w_os_next    = '0;
            w_bit_next   = '0;
          end else begin
            w_os_next = r_os_cnt + c_OS_W'(1);
          end
        end
        DATA: begin
          if (r_os_cnt == c_OS_LAST) begin
            w_os_next = '0;
            if (r_bit_cnt == c_BIT_LAST) begin
              w_state_next = PARITY_EN ? PARITY : STOP;
            end else begin
              w_bit_next = r_bit_cnt + c_BIT_W'(1);
            end
          end else begin
            w_os_next = r_os_cnt + c_OS_W'(1);
          end
        end
        PARITY: begin
          if (r_os_cnt == c_OS_LAST) begin
            w_state_next = STOP;
            w_os_next    = '0;
          end else begin
            w_os_next = r_os_cnt + c_OS_W'(1);
          end
        end
        STOP: begin
          // Deciding mid-stop-bit lets a back-to-back start edge be caught.
          if (w_win_end) begin
            w_frame_done = 1'b1;
            w_os_next    = '0;
            w_state_next = w_is_break ? BREAK : IDLE;
          end else begin
            w_os_next = r_os_cnt + c_OS_W'(1);
          end
        end
        BREAK: begin
          if (w_rx_s) begin
            w_state_next = IDLE;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_os_next    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift  <= '0;
      r_parity <= 1'b0;
    end else begin
      if (w_win_end && (r_state == DATA)) begin
        r_shift <= {w_maj, r_shift[DATA_W-1:1]};
      end
      if (w_win_end && (r_state == PARITY)) begin
        r_parity <= w_maj;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_fe      <= 1'b0;
      r_pe      <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_frame_done && !w_is_break) begin
        if (!r_valid || out_ready) begin
          r_data  <= r_shift;
          r_fe    <= ~w_maj;
          r_pe    <= w_par_err;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic r_break;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_break <= 1'b0;
    end else begin
      r_break <= w_frame_done && w_is_break;
    end
  end

  assign break_detect = r_break;
`else
  assign break_detect = 1'b0;
`endif

  assign data_out     = r_data;
  assign out_valid    = r_valid;
  assign frame_error  = r_fe;
  assign parity_error = r_pe;
  assign overrun      = r_overrun;
  assign busy         = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// +------------------------------------------------------------------+
// | tb_uart_receiver: scoreboard bench for uart_receiver (8N1 + 8E1). |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       oversample_tick = 1'b0;
  logic [1:0] tick_cnt = 2'd0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_cnt        <= tick_cnt + 2'd1;
    oversample_tick <= (tick_cnt == 2'd3);
  end

  logic       rx_def = 1'b1, ready_def = 1'b1;
  logic [7:0] data_def;
  logic       valid_def, fe_def, pe_def, ovr_def, busy_def, brk_def;
  logic       rx_par = 1'b1, ready_par = 1'b1;
  logic [7:0] data_par;
  logic       valid_par, fe_par, pe_par, ovr_par, busy_par, brk_par;

  uart_receiver u_dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .oversample_tick (oversample_tick),
    .RsRx            (rx_def),
    .data_out        (data_def),
    .out_valid       (valid_def),
    .out_ready       (ready_def),
    .frame_error     (fe_def),
    .parity_error    (pe_def),
    .overrun         (ovr_def),
    .busy            (busy_def),
    .break_detect    (brk_def)
  );

  uart_receiver #(
    .PARITY_EN   (1'b1),
    .PARITY_EVEN (1'b1)
  ) u_dut_par (
    .clk             (clk),
    .reset_n         (reset_n),
    .oversample_tick (oversample_tick),
    .RsRx            (rx_par),
    .data_out        (data_par),
    .out_valid       (valid_par),
    .out_ready       (ready_par),
    .frame_error     (fe_par),
    .parity_error    (pe_par),
    .overrun         (ovr_par),
    .busy            (busy_par),
    .break_detect    (brk_par)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc_def = 0, n_acc_par = 0;
  int n_ovr = 0, n_brk = 0;
  logic [9:0] q_def[$];
  logic [9:0] q_par[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: a handshake occurs at the next posedge when valid && ready here.
  always begin
    @(negedge clk);
    #2;
    if (valid_def && ready_def) begin
      n_acc_def++;
      if (q_def.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_frame_def: got data 0x%0h fe %0b pe %0b, required none",
                 data_def, fe_def, pe_def);
      end else begin
        check("frame_def {data,fe,pe}", {22'd0, data_def, fe_def, pe_def}, {22'd0, q_def.pop_front()});
      end
    end
    if (valid_par && ready_par) begin
      n_acc_par++;
      if (q_par.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_frame_par: got data 0x%0h fe %0b pe %0b, required none",
                 data_par, fe_par, pe_par);
      end else begin
        check("frame_par {data,fe,pe}", {22'd0, data_par, fe_par, pe_par}, {22'd0, q_par.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (ovr_def) n_ovr++;
    if (brk_def) n_brk++;
  end

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_par = v;
    else     rx_def = v;
  endtask

  // glitch inverts 4 clocks (exactly one tick) landing on window sample 7
  task automatic send_bit(input bit sel, input logic v, input bit glitch, input int len);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      drive(sel, (glitch && c >= 28 && c < 32) ? ~v : v);
    end
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                            input logic p, input logic stop, input int glitch_bit);
    send_bit(sel, 1'b0, 1'b0, 64);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i], glitch_bit == i, 64);
    if (has_par) send_bit(sel, p, 1'b0, 64);
    // a low stop bit is cut short so its tail is rejected as a start glitch
    send_bit(sel, stop, 1'b0, stop ? 64 : 42);
    send_bit(sel, 1'b1, 1'b0, 64);
  endtask

  int a0, o0, b0;

  initial begin
    repeat (5) @(negedge clk);
    check("reset out_valid", {31'd0, valid_def}, 32'd0);
    check("reset data_out", {24'd0, data_def}, 32'd0);
    check("reset busy", {31'd0, busy_def}, 32'd0);
    check("reset flags {fe,pe,ovr,brk}", {28'd0, fe_def, pe_def, ovr_def, brk_def}, 32'd0);
    check("reset par out_valid/busy", {30'd0, valid_par, busy_par}, 32'd0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    q_def.push_back({8'h55, 1'b0, 1'b0});
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, -1);
    repeat (10) @(negedge clk);
    check("clean out_valid single cycle", {31'd0, valid_def}, 32'd0);

    a0 = n_acc_def;
    @(negedge clk);
    rx_def = 1'b0;
    repeat (7) @(negedge clk);
    check("glitch busy after start", {31'd0, busy_def}, 32'd1);
    @(negedge clk);
    rx_def = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch busy back low", {31'd0, busy_def}, 32'd0);
    check("glitch no frame", n_acc_def, a0);

    q_par.push_back({8'hA3, 1'b0, 1'b0});
    send_frame(1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 3);
    q_par.push_back({8'hA3, 1'b0, 1'b1});
    send_frame(1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, -1);

    @(negedge clk);
    ready_def = 1'b0;
    q_def.push_back({8'h3C, 1'b1, 1'b0});
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, -1);
    check("held out_valid", {31'd0, valid_def}, 32'd1);
    check("held data_out", {24'd0, data_def}, 32'h3C);
    check("held frame_error", {31'd0, fe_def}, 32'd1);
    o0 = n_ovr;
    send_frame(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1, -1);
    check("overrun pulses", n_ovr - o0, 1);
    check("overrun keeps data_out", {24'd0, data_def}, 32'h3C);
    check("overrun keeps frame_error", {31'd0, fe_def}, 32'd1);
    @(negedge clk);
    ready_def = 1'b1;
    repeat (2) @(negedge clk);
    check("out_valid drops on ready", {31'd0, valid_def}, 32'd0);

    fork
      send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, -1);
      begin
        repeat (340) @(posedge clk);
        #3;
        check("busy in data bit 4", {31'd0, busy_def}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("async reset busy", {31'd0, busy_def}, 32'd0);
        check("async reset data_out", {24'd0, data_def}, 32'd0);
        check("async reset par data_out", {24'd0, data_par}, 32'd0);
        check("async reset flags", {29'd0, valid_def, fe_def, pe_par}, 32'd0);
      end
    join
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    q_def.push_back({8'h81, 1'b0, 1'b0});
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, -1);

`ifdef UART_RX_BREAK_DETECT_EN
    b0 = n_brk;
    a0 = n_acc_def;
    @(negedge clk);
    rx_def = 1'b0;
    repeat (1280) @(negedge clk);
    rx_def = 1'b1;
    repeat (128) @(negedge clk);
    check("break pulses once", n_brk - b0, 1);
    check("break no frame", n_acc_def, a0);
    check("break exits to idle", {31'd0, busy_def}, 32'd0);
    q_def.push_back({8'h41, 1'b0, 1'b0});
    send_frame(1'b0, 8'h41, 1'b0, 1'b0, 1'b1, -1);
`else
    q_def.push_back({8'h00, 1'b1, 1'b0});
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, -1);
    check("no break pulse", n_brk, 0);
`endif

    repeat (50) @(negedge clk);
    check("def scoreboard drained", q_def.size(), 0);
    check("par scoreboard drained", q_par.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART receive path, the counterpart of the existing transmitter in the Basys3 wrapper.
- Samples `RsRx` using the shared oversample tick from the controller's baud generator.
- Recovers LSB-first frames (start, `DATA_W` data bits, optional parity, stop) by majority vote.
- Presents each byte on a valid/ready handshake with per-byte error sideband, for the controller's memory-mapped RX register.

Parameters:
- DATA_W, 8, data bits per frame.
- OVERSAMPLE_RATE, 16, oversample ticks per bit; even, ≥ 8.
- START_SAMPLES, OVERSAMPLE_RATE/4, consecutive low samples needed to accept a start bit.
- DATA_SAMPLES, 3, samples per data/parity/stop bit for majority vote; odd, ≤ OVERSAMPLE_RATE/2.
- PARITY_EN, 0, 1 = frame carries a parity bit.
- PARITY_EVEN, 1, 1 = even parity, 0 = odd parity.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- oversample_tick  in  1  one-cycle strobe at OVERSAMPLE_RATE × baud.
- RsRx  in  1  serial line, idle high, asynchronous to clk.
- data_out  out  DATA_W  received byte.
- out_valid  out  1  data_out and flags are valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- frame_error  out  1  stop bit sampled 0; qualified by out_valid.
- parity_error  out  1  parity mismatch; qualified by out_valid; 0 when PARITY_EN=0.
- overrun  out  1  one-cycle pulse: completed frame dropped because out_valid was still pending.
- busy  out  1  state ≠ IDLE.
- break_detect  out  1  one-cycle pulse on break (see Optional Feature).

Behaviour:
- Reset (async, any point, including mid-frame):
  - state=IDLE; synchronizer flops=1; os_cnt=0; bit_cnt=0.
  - data_out=0, out_valid=0, all flags/pulses=0, busy=0.
- Input sync:
  - RsRx passes through two flops → rx_s.
  - All sampling uses rx_s on cycles with oversample_tick=1; no action on other cycles.
- os_cnt: counts 0..OVERSAMPLE_RATE-1 within a bit, wraps to 0 at each bit boundary.
- Sampling window:
  - Centre C = OVERSAMPLE_RATE/2.
  - Samples are taken at os_cnt in [C-DATA_SAMPLES/2, C+DATA_SAMPLES/2].
  - Bit value = majority of the samples.
- States:
  - IDLE: on a tick with rx_s=0, go to START with os_cnt=1. That tick counts as low sample 1.
  - START:
    - While os_cnt < START_SAMPLES, any tick with rx_s=1 returns to IDLE (glitch rejection).
    - At os_cnt=OVERSAMPLE_RATE-1, go to DATA with bit_cnt=0 and os_cnt=0.
  - DATA:
    - Majority value shifts in LSB-first into the shift register at the window end.
    - At os_cnt=OVERSAMPLE_RATE-1: if bit_cnt=DATA_W-1, go to PARITY (PARITY_EN) or STOP; else bit_cnt+1.
  - PARITY: capture the bit at the window end; go to STOP at os_cnt=OVERSAMPLE_RATE-1.
  - STOP:
    - Decide at the window end, not at end of bit, to allow early resync.
    - Commit the frame, then go to IDLE on the same tick.
- Parity check:
  - parity_error = (XOR(data) ^ parity_bit) ≠ (PARITY_EVEN ? 0 : 1).
- Commit:
  - If out_valid=0 or out_ready=1 that cycle: load data_out, frame_error=~stop, parity_error; out_valid=1 the next cycle.
  - Otherwise: pulse overrun, discard the new frame, keep the old data and flags unchanged.
- Handshake:
  - out_valid stays high until out_ready.
  - Accept and commit in the same cycle: the new frame replaces the old, out_valid stays 1, no overrun.
- Latency: RsRx edge → rx_s is 2 cycles. Stop decision tick → out_valid is 1 cycle.
- Tick spacing: oversample_tick spacing ≥ 2 cycles is supported; back-to-back ticks (spacing 1) are also legal.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- Defined:
  - A frame with all data bits 0 and stop=0 is a break.
  - break_detect pulses for one cycle, no commit occurs, and no overrun is raised.
  - Enter state BREAK, which exits to IDLE on the first tick with rx_s=1. busy=1 while in BREAK.
- Undefined:
  - No BREAK state; break_detect is tied to 0.
  - The frame commits as data 0x00 with frame_error=1.

Decomposition:
- Package uart_pkg holds:
  - uart_rx_state_e enum {IDLE, START, DATA, PARITY, STOP, BREAK}.
  - Default constants OVERSAMPLE_RATE_DEFAULT=16 and DATA_SAMPLES_DEFAULT=3.
  - Parity function calc_parity(data, even).
- Sub-module: uart_rx_sampler. It contains the 2-flop synchronizer and the majority-vote accumulator with clear/sample/result controls. It is reused by the future flow-control inputs.

Test Plan:
- Clean frame:
  - Stimulus: tick every 4 clocks; send 0x55, 8N1, stop=1; out_ready=1.
  - Response: out_valid one cycle, data_out=0x55, frame_error=0, parity_error=0.
- Glitch rejection: RsRx low for 2 ticks then high (START_SAMPLES=4) → returns to IDLE, busy low, no out_valid.
- Majority vote / parity:
  - Stimulus: PARITY_EN=1, PARITY_EVEN=1; send 0xA3 with parity 0; invert one centre-adjacent sample on bit 3.
  - Response: data_out=0xA3, parity_error=0.
  - Then send 0xA3 with parity 1 → parity_error=1.
- Framing and overrun:
  - Stimulus: send 0x3C with stop=0, out_ready=0; then send 0x7E.
  - Response: first frame held with data_out=0x3C, frame_error=1. Second commit pulses overrun, data_out stays 0x3C.
  - Raise out_ready → out_valid drops.
- Reset mid-frame: assert reset_n low during DATA bit 4 (async, between clock edges) → all outputs 0 immediately, state IDLE. A next full frame 0x81 is received correctly.
- Break (macro defined): RsRx low for 2 frame times → break_detect pulses once, no out_valid. Line high, then frame 0x41 → data_out=0x41.
